// File: rtl/mips_avalon_mem_slave_if.sv
// Avalon-MM bus bundle between the CPU bus controller (master) and the memory responder (slave).
interface mips_avalon_mem_slave_if;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic        waitrequest;
  logic [31:0] readdata;
  logic        err;

  modport master (
    output address, read, write, writedata, byteenable,
    input  waitrequest, readdata, err
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output waitrequest, readdata, err
  );
endinterface

// File: rtl/mips_avalon_mem_slave.sv
// Avalon-MM memory responder with boot and data windows, programmable stall and sticky error.
// Optional macro AVALON_RAND_WAIT_EN adds an LFSR-driven 0..3 cycle random stall per transfer.
module mips_avalon_mem_slave #(
  parameter logic [31:0] BOOT_BASE   = 32'hBFC0_0000,
  parameter int unsigned BOOT_WORDS  = 1024,
  parameter logic [31:0] DATA_BASE   = 32'h0000_1000,
  parameter int unsigned DATA_WORDS  = 4096,
  parameter int unsigned WAIT_CYCLES = 0,
  parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
  input logic                     clk,
  input logic                     reset,
  mips_avalon_mem_slave_if.slave  bus_if
);

  localparam int unsigned BootAw    = (BOOT_WORDS > 1) ? $clog2(BOOT_WORDS) : 1;
  localparam int unsigned DataAw    = (DATA_WORDS > 1) ? $clog2(DATA_WORDS) : 1;
  localparam logic [32:0] BootBytes = 33'(BOOT_WORDS) << 2;
  localparam logic [32:0] DataBytes = 33'(DATA_WORDS) << 2;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      r_state, w_state_next;
  logic [4:0]  r_cnt, w_cnt_next;
  logic [31:0] r_readdata;
  logic        r_err;

  logic              r_is_boot;
  logic [BootAw-1:0] r_boot_idx;
  logic [DataAw-1:0] r_data_idx;
  logic [31:0]       r_wdata;
  logic [3:0]        r_be;
  logic              r_rd;
  logic              r_wr;
  logic              r_req_err;

  logic [31:0] r_boot_mem [BOOT_WORDS];
  logic [31:0] r_data_mem [DATA_WORDS];

  logic        w_req;
  logic [31:0] w_boot_off, w_data_off;
  logic        w_boot_hit, w_data_hit, w_req_err;
  logic        w_accept, w_commit, w_abort, w_mem_we;
  logic [1:0]  w_rand_add;
  logic [31:0] w_rd_word;

  assign w_req      = bus_if.read | bus_if.write;
  // Unsigned wrap makes addresses below the base fail the range compare too.
  assign w_boot_off = bus_if.address - BOOT_BASE;
  assign w_data_off = bus_if.address - DATA_BASE;
  assign w_boot_hit = {1'b0, w_boot_off} < BootBytes;
  assign w_data_hit = {1'b0, w_data_off} < DataBytes;
  assign w_req_err  = ~(w_boot_hit | w_data_hit) | (bus_if.address[1:0] != 2'b00) |
                      (bus_if.read & bus_if.write) | (bus_if.write & (bus_if.byteenable == 4'h0));

`ifdef AVALON_RAND_WAIT_EN
  logic [7:0] r_lfsr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_lfsr <= LFSR_SEED;
    end else if (w_accept) begin
      r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
    end
  end

  assign w_rand_add = r_lfsr[1:0];
`else
  logic w_unused_seed;
  assign w_unused_seed = ^LFSR_SEED;
  assign w_rand_add    = 2'd0;
`endif

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_accept     = 1'b0;
    w_commit     = 1'b0;
    w_abort      = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_req) begin
          w_accept     = 1'b1;
          w_cnt_next   = 5'(WAIT_CYCLES) + 5'(w_rand_add);
          w_state_next = StWait;
        end
      end
      StWait: begin
        if (!w_req) begin
          w_abort      = 1'b1;
          w_cnt_next   = 5'd0;
          w_state_next = StIdle;
        end else if (r_cnt == 5'd0) begin
          w_commit     = 1'b1;
          w_state_next = StResp;
        end else begin
          w_cnt_next = r_cnt - 5'd1;
        end
      end
      StResp:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  assign w_rd_word = r_is_boot ? r_boot_mem[r_boot_idx] : r_data_mem[r_data_idx];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= StIdle;
      r_cnt      <= 5'd0;
      r_readdata <= 32'h0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (w_abort || (w_commit && r_req_err)) begin
        r_err <= 1'b1;
      end
      if (w_commit) begin
        if (r_req_err) begin
          r_readdata <= 32'h0;
        end else if (r_rd) begin
          r_readdata <= w_rd_word;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_is_boot  <= w_boot_hit;
      r_boot_idx <= w_boot_off[BootAw+1:2];
      r_data_idx <= w_data_off[DataAw+1:2];
      r_wdata    <= bus_if.writedata;
      r_be       <= bus_if.byteenable;
      r_rd       <= bus_if.read;
      r_wr       <= bus_if.write;
      r_req_err  <= w_req_err;
    end
  end

  // Memories have no reset; a reset on the commit edge suppresses the write.
  assign w_mem_we = w_commit & r_wr & ~r_req_err & ~reset;

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (r_be[b]) begin
          if (r_is_boot) begin
            r_boot_mem[r_boot_idx][8*b +: 8] <= r_wdata[8*b +: 8];
          end else begin
            r_data_mem[r_data_idx][8*b +: 8] <= r_wdata[8*b +: 8];
          end
        end
      end
    end
  end

  assign bus_if.waitrequest = w_req & (r_state != StResp);
  assign bus_if.readdata    = r_readdata;
  assign bus_if.err         = r_err;

endmodule

// File: tb/tb_mips_avalon_mem_slave.sv
// Scoreboard bench for mips_avalon_mem_slave: directed cases plus randomized traffic vs a memory model.
module tb_mips_avalon_mem_slave;
  localparam logic [31:0] BootBase  = 32'hBFC0_0000;
  localparam int unsigned BootWords = 1024;
  localparam logic [31:0] DataBase  = 32'h0000_1000;
  localparam int unsigned DataWords = 4096;
  localparam int unsigned WaitCyc   = 2;
  localparam logic [7:0]  Seed      = 8'hA5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mips_avalon_mem_slave_if bus_if ();

  mips_avalon_mem_slave #(
    .BOOT_BASE  (BootBase),
    .BOOT_WORDS (BootWords),
    .DATA_BASE  (DataBase),
    .DATA_WORDS (DataWords),
    .WAIT_CYCLES(WaitCyc),
    .LFSR_SEED  (Seed)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus_if(bus_if)
  );

  typedef struct {
    bit          is_rd;
    bit          chk_data;
    logic [31:0] data;
    bit          err;
    int          stalls;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mem_m[logic [31:0]];
  bit          err_m;
  logic [7:0]  lfsr_m;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  function automatic bit in_window(input logic [31:0] a);
    longint unsigned x = longint'(a);
    longint unsigned bb = longint'(BootBase);
    longint unsigned db = longint'(DataBase);
    return (x >= bb && x < bb + 4 * BootWords) || (x >= db && x < db + 4 * DataWords);
  endfunction

  // Stall cycles seen by the master for one accepted request.
  function automatic int next_stalls();
    int s = WaitCyc + 2;
`ifdef AVALON_RAND_WAIT_EN
    s += int'(lfsr_m[1:0]);
    lfsr_m = {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
`endif
    return s;
  endfunction

  task automatic do_reset();
    bus_if.read  = 1'b0;
    bus_if.write = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    err_m  = 1'b0;
    lfsr_m = Seed;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic xfer(input logic [31:0] addr, input bit rd, input bit wr,
                      input logic [31:0] data, input logic [3:0] be);
    exp_t        e;
    bit          bad;
    logic [31:0] w;
    int          n;
    bad        = !in_window(addr) || (addr[1:0] != 2'b00) || (rd && wr) || (wr && be == 4'h0);
    e.stalls   = next_stalls();
    e.is_rd    = rd;
    e.chk_data = 1'b1;
    e.data     = 32'h0;
    if (bad) begin
      err_m = 1'b1;
    end else if (rd) begin
      if (mem_m.exists(addr)) e.data = mem_m[addr];
      else e.chk_data = 1'b0;
    end else if (mem_m.exists(addr)) begin
      w = mem_m[addr];
      for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = data[8*b +: 8];
      mem_m[addr] = w;
    end else if (be == 4'hF) begin
      mem_m[addr] = data;
    end
    e.err = err_m;
    exp_q.push_back(e);

    bus_if.address    = addr;
    bus_if.writedata  = data;
    bus_if.byteenable = be;
    bus_if.read       = rd;
    bus_if.write      = wr;
    n = 0;
    forever begin
      @(negedge clk);
      if (!bus_if.waitrequest) break;
      n++;
      if (n > 64) begin
        check("xfer_timeout", 32'(n), 32'd0);
        break;
      end
    end
    @(posedge clk);
    #1;
    bus_if.read  = 1'b0;
    bus_if.write = 1'b0;
  endtask

  // Monitor: counts stall cycles and checks each completed transfer against the scoreboard.
  int   stall_cnt = 0;
  exp_t mon_e;
  always @(negedge clk) begin
    if (reset || !(bus_if.read || bus_if.write)) begin
      stall_cnt = 0;
    end else if (bus_if.waitrequest) begin
      stall_cnt++;
    end else begin
      if (exp_q.size() == 0) begin
        check("sb_underflow", 32'(exp_q.size()), 32'd1);
      end else begin
        mon_e = exp_q.pop_front();
        check("stall_len", 32'(stall_cnt), 32'(mon_e.stalls));
        check("err", {31'h0, bus_if.err}, {31'h0, mon_e.err});
        if (mon_e.is_rd && mon_e.chk_data) check("readdata", bus_if.readdata, mon_e.data);
      end
      stall_cnt = 0;
    end
  end

  function automatic logic [31:0] rand_addr();
    logic [31:0] edges [6];
    edges[0] = BootBase + 4 * BootWords - 4;
    edges[1] = BootBase + 4 * BootWords;
    edges[2] = DataBase - 4;
    edges[3] = DataBase + 4 * DataWords - 4;
    edges[4] = DataBase + 4 * DataWords;
    edges[5] = 32'h0;
    case ($urandom_range(0, 7))
      0, 1, 2: return BootBase + 4 * $urandom_range(0, 7);
      3, 4, 5: return DataBase + 4 * $urandom_range(0, 7);
      6:       return DataBase + $urandom_range(0, 31);
      default: return edges[$urandom_range(0, 5)];
    endcase
  endfunction

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int          op;
    bus_if.address    = 32'h0;
    bus_if.read       = 1'b0;
    bus_if.write      = 1'b0;
    bus_if.writedata  = 32'h0;
    bus_if.byteenable = 4'h0;
    do_reset();
    check("rst_waitrequest", {31'h0, bus_if.waitrequest}, 32'h0);
    check("rst_readdata", bus_if.readdata, 32'h0);
    check("rst_err", {31'h0, bus_if.err}, 32'h0);

    // Boot word load and read.
    xfer(BootBase, 1'b0, 1'b1, 32'h2402_0005, 4'hF);
    xfer(BootBase, 1'b1, 1'b0, 32'h0, 4'hF);

    // Byte-enable merge, then readdata must hold across a write.
    xfer(32'h1000, 1'b0, 1'b1, 32'h1122_3344, 4'hF);
    xfer(32'h1000, 1'b0, 1'b1, 32'hAABB_CCDD, 4'b0101);
    xfer(32'h1000, 1'b1, 1'b0, 32'h0, 4'hF);
    xfer(32'h1020, 1'b0, 1'b1, 32'h0BAD_F00D, 4'hF);
    check("rd_hold", bus_if.readdata, 32'h11BB_33DD);

    // Unmapped read, reset, misaligned write.
    xfer(32'h0, 1'b1, 1'b0, 32'h0, 4'hF);
    do_reset();
    check("rst2_err", {31'h0, bus_if.err}, 32'h0);
    check("rst2_readdata", bus_if.readdata, 32'h0);
    xfer(32'h1002, 1'b0, 1'b1, 32'hFFFF_FFFF, 4'hF);
    xfer(32'h1000, 1'b1, 1'b0, 32'h0, 4'hF);

    // Protocol abort: write dropped mid-stall.
    do_reset();
    xfer(32'h1004, 1'b0, 1'b1, 32'h5566_7788, 4'hF);
    bus_if.address    = 32'h1004;
    bus_if.writedata  = 32'h9999_9999;
    bus_if.byteenable = 4'hF;
    bus_if.write      = 1'b1;
    void'(next_stalls());
    idle(2);
    bus_if.write = 1'b0;
    err_m = 1'b1;
    idle(2);
    check("abort_err", {31'h0, bus_if.err}, {31'h0, err_m});
    check("abort_waitreq", {31'h0, bus_if.waitrequest}, 32'h0);
    xfer(32'h1004, 1'b1, 1'b0, 32'h0, 4'hF);

    // Back-to-back write then read.
    do_reset();
    xfer(32'h1008, 1'b0, 1'b1, 32'hDEAD_BEEF, 4'hF);
    xfer(32'h1008, 1'b1, 1'b0, 32'h0, 4'hF);

    // Window edges and remaining error kinds.
    xfer(BootBase + 4 * BootWords - 4, 1'b0, 1'b1, 32'hCAFE_0001, 4'hF);
    xfer(BootBase + 4 * BootWords - 4, 1'b1, 1'b0, 32'h0, 4'hF);
    xfer(BootBase + 4 * BootWords, 1'b1, 1'b0, 32'h0, 4'hF);
    do_reset();
    xfer(32'h1008, 1'b1, 1'b1, 32'h1234_5678, 4'hF);
    do_reset();
    xfer(32'h1008, 1'b0, 1'b1, 32'h1234_5678, 4'h0);
    xfer(32'h1008, 1'b1, 1'b0, 32'h0, 4'hF);

    // Reset in the middle of a write stall.
    do_reset();
    xfer(32'h1010, 1'b0, 1'b1, 32'h0102_0304, 4'hF);
    bus_if.address    = 32'h1010;
    bus_if.writedata  = 32'hFFFF_0000;
    bus_if.byteenable = 4'hF;
    bus_if.write      = 1'b1;
    idle(1);
    do_reset();
    check("midrst_err", {31'h0, bus_if.err}, 32'h0);
    check("midrst_readdata", bus_if.readdata, 32'h0);
    xfer(32'h1010, 1'b1, 1'b0, 32'h0, 4'hF);

    // 16 reads from a fresh LFSR state.
    do_reset();
    for (int i = 0; i < 16; i++) xfer(DataBase + 4 * (i % 8), 1'b1, 1'b0, 32'h0, 4'hF);

    // Randomized traffic.
    for (int i = 0; i < 250; i++) begin
      a  = rand_addr();
      op = $urandom_range(0, 9);
      if (op < 4) begin
        xfer(a, 1'b0, 1'b1, $urandom(),
             ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF);
      end else if (op < 9) begin
        xfer(a, 1'b1, 1'b0, 32'h0, 4'hF);
      end else begin
        xfer(a, 1'b1, 1'b1, $urandom(), 4'hF);
      end
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end

    idle(4);
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mips_avalon_mem_slave.md
# mips_avalon_mem_slave

Avalon memory-mapped responder (slave) that serves the CPU's bus controller port in simulation and on FPGA. It holds two word-addressed memory windows: boot/instruction space at the reset vector and a data window. It stretches every transfer with a programmable number of `waitrequest` cycles and applies `byteenable` on writes. It flags protocol and address errors in a sticky status bit.

## Interface
Parameters:
- `BOOT_BASE`, default `32'hBFC0_0000`: byte base address of the boot window.
- `BOOT_WORDS`, default 1024: depth of the boot window in 32-bit words (power of 2).
- `DATA_BASE`, default `32'h0000_1000`: byte base address of the data window.
- `DATA_WORDS`, default 4096: depth of the data window in words (power of 2).
- `WAIT_CYCLES`, default 0: extra stall cycles per transfer, range 0–15.
- `LFSR_SEED`, default `8'hA5`: non-zero seed for the random-stall LFSR.

Ports (clock `clk`; reset `reset`, synchronous, active-high):
- `clk` input 1: clock, all state updates on the rising edge.
- `reset` input 1: synchronous, active-high.
- `address` input 32: byte address from the master.
- `read` input 1: read request.
- `write` input 1: write request.
- `writedata` input 32: write data.
- `byteenable` input 4: bit n enables byte lane [8n+7:8n].
- `waitrequest` output 1: stall; the master holds all inputs stable while it is high.
- `readdata` output 32: read data, valid in the cycle `read`=1 and `waitrequest`=0.
- `err` output 1: sticky error flag.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - On `read` or `write`, latch the request, load the stall counter with `WAIT_CYCLES` (plus the random term when that feature is compiled in), and go to WAIT.
  - The memory access is performed on the WAIT→RESP edge. Read data is registered into `readdata`. Writes merge the enabled bytes into the addressed word.
- WAIT: decrement the counter each cycle; when it is 0, go to RESP.
- RESP: go to IDLE next cycle; `waitrequest`=0 in this cycle.
- `waitrequest` = (`read`|`write`) & (state != RESP), combinational from state and the request inputs; it is 0 whenever no request is present.
- Address decode:
  - Boot hit: `address` in [BOOT_BASE, BOOT_BASE+4*BOOT_WORDS).
  - Data hit: `address` in [DATA_BASE, DATA_BASE+4*DATA_WORDS).
  - Word index = (`address`−base)>>2.
- Error cases, each sets `err` (sticky until reset). In all of them no memory word changes and `readdata`=0 in RESP; timing stays identical to a normal transfer.
  - Miss (address in neither window).
  - `address[1:0]`≠0.
  - `read`&`write` both high.
  - `byteenable`=0 on a write.
- Request dropped while in WAIT: abort to IDLE with no memory access, set `err`.
- A read-enabled `readdata` holds its value until the next completed read.
- Reset: state IDLE, counter 0, `readdata`=0, `err`=0, LFSR reloaded with `LFSR_SEED`. Memory contents are unaffected. Reset mid-transfer aborts it with no write performed.

## Timing
- Request first seen in cycle 0 → `waitrequest`=1 in cycles 0..WAIT_CYCLES+1, 0 in cycle WAIT_CYCLES+2.
- Minimum transfer is 3 cycles (WAIT_CYCLES=0).
- Write data is committed at the edge ending the last `waitrequest`=1 cycle. A read issued later returns the new value.
- Back-to-back requests: a new request may be presented in the cycle after RESP; the next IDLE cycle accepts it.
- The sampled request (address, data, byteenable, op) is taken in cycle 0. Changes to it during the stall are a protocol error only if `read`/`write` deasserts.

## Configuration
- `AVALON_RAND_WAIT_EN` defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4) advances once per accepted request.
  - `lfsr[1:0]` (0–3) is added to `WAIT_CYCLES` for that transfer.
- Not defined: the LFSR is absent and stalls are exactly `WAIT_CYCLES`.

## Test plan
- Boot read, WAIT_CYCLES=2, boot word 0 preloaded `32'h2402_0005`: read `0xBFC00000` → `waitrequest` high 4 cycles, then low with `readdata`=`0x24020005`; `err`=0.
- Byte-enable write: data word at `0x1000` = `0x11223344`; write `0xAABBCCDD` with `byteenable`=`4'b0101` → subsequent read returns `0x11BB33DD`.
- Unmapped/misaligned access: read `0x00000000` → normal latency, `readdata`=0, `err`=1. After reset, write `0x1002` → word at `0x1000` unchanged, `err`=1.
- Protocol abort: assert `write` to `0x1004`, drop it after 1 cycle with WAIT_CYCLES=3 → FSM returns to IDLE, word at `0x1004` unchanged, `err`=1.
- Back-to-back: write `0xDEADBEEF` to `0x1008`, then read `0x1008` in the cycle after RESP → read completes 3 cycles later (WAIT_CYCLES=0) with `0xDEADBEEF`.
- With `AVALON_RAND_WAIT_EN`, seed `8'hA5`: run 16 reads → each stall length lies in [WAIT_CYCLES+2, WAIT_CYCLES+5], the sequence matches a reference LFSR model, and data is always correct.
